// File: rtl/ddr_refresh_if.sv
// Refresh handshake between the DDR4 command scheduler (master) and the refresh timer (slave).
interface ddr_refresh_if;
  logic       ini_done;
  logic       act_idle;
  logic       rw_idle;
  logic       clear_refresh;
  logic       refresh_almost;
  logic       refresh_rdy;
  logic       refresh_urgent;
  logic       busy;
  logic       refresh_done;
  logic [3:0] pend_cnt;

  modport master (
    output ini_done, act_idle, rw_idle, clear_refresh,
    input  refresh_almost, refresh_rdy, refresh_urgent, busy, refresh_done, pend_cnt
  );

  modport slave (
    input  ini_done, act_idle, rw_idle, clear_refresh,
    output refresh_almost, refresh_rdy, refresh_urgent, busy, refresh_done, pend_cnt
  );
endinterface

// File: rtl/ddr_refresh_ctrl.sv
// tREFI/tRFC refresh timer with JEDEC postpone tracking; all flags registered (1-cycle response to inputs).
// Urgent refresh overrides idle backpressure; REF_PULL_IN_EN enables pull-in refresh credits.
module ddr_refresh_ctrl #(
  parameter int TREFI         = 6240,
  parameter int TRFC          = 280,
  parameter int ALMOST_WINDOW = 64,
  parameter int MAX_POSTPONE  = 8,
  parameter int CNT_W         = 16
) (
  input logic          CK_t,
  input logic          RESET_n,
  ddr_refresh_if.slave rif
);

  typedef enum logic [1:0] {IDLE, COUNT, REQ, RFC} state_t;

  localparam logic [CNT_W-1:0] TREFI_LAST = CNT_W'(TREFI - 1);
  localparam logic [CNT_W-1:0] TRFC_LAST  = CNT_W'(TRFC - 1);
  localparam logic [CNT_W-1:0] ALMOST_AT  = CNT_W'(TREFI - ALMOST_WINDOW);
  localparam logic [3:0]       PEND_MAX   = 4'(MAX_POSTPONE);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] refresh_cnt, refresh_cnt_nxt;
  logic [CNT_W-1:0] rfc_cnt, rfc_cnt_nxt;
  logic [3:0]       pend, pend_nxt;
  logic             almost_q, almost_nxt;
  logic             rdy_q, urgent_q, busy_q;
  logic             done_q, done_nxt;
  logic             both_idle, urgent_now, wrap, clear_ok, due;
`ifdef REF_PULL_IN_EN
  logic [3:0]       credit, credit_nxt;
  logic [3:0]       idle_cnt, idle_cnt_nxt;
`endif

  assign both_idle  = rif.act_idle & rif.rw_idle;
  assign urgent_now = (pend == PEND_MAX);
  assign wrap       = (state != IDLE) && (refresh_cnt == TREFI_LAST);
  assign due        = urgent_now || ((pend != 4'd0) && both_idle);
`ifdef REF_PULL_IN_EN
  assign clear_ok   = (state == REQ) && rif.clear_refresh && ((pend != 4'd0) || (credit < PEND_MAX));
`else
  assign clear_ok   = (state == REQ) && rif.clear_refresh && (pend != 4'd0);
`endif

  always_ff @(posedge CK_t or negedge RESET_n) begin
    if (!RESET_n) begin
      state       <= IDLE;
      refresh_cnt <= '0;
      rfc_cnt     <= '0;
      pend        <= '0;
      almost_q    <= 1'b0;
      rdy_q       <= 1'b0;
      urgent_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef REF_PULL_IN_EN
      credit      <= '0;
      idle_cnt    <= '0;
`endif
    end else begin
      state       <= state_nxt;
      refresh_cnt <= refresh_cnt_nxt;
      rfc_cnt     <= rfc_cnt_nxt;
      pend        <= pend_nxt;
      almost_q    <= almost_nxt;
      rdy_q       <= (state_nxt == REQ);
      urgent_q    <= (pend_nxt == PEND_MAX);
      busy_q      <= (state_nxt == RFC);
      done_q      <= done_nxt;
`ifdef REF_PULL_IN_EN
      credit      <= credit_nxt;
      idle_cnt    <= idle_cnt_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt       = state;
    refresh_cnt_nxt = refresh_cnt;
    rfc_cnt_nxt     = rfc_cnt;
    pend_nxt        = pend;
    done_nxt        = 1'b0;
    almost_nxt      = 1'b0;
`ifdef REF_PULL_IN_EN
    credit_nxt      = credit;
    idle_cnt_nxt    = 4'd0;
`endif
    if (!rif.ini_done) begin
      // soft reset: everything returns to its post-reset value
      state_nxt       = IDLE;
      refresh_cnt_nxt = '0;
      rfc_cnt_nxt     = '0;
      pend_nxt        = '0;
`ifdef REF_PULL_IN_EN
      credit_nxt      = '0;
`endif
    end else begin
      if (state != IDLE)
        refresh_cnt_nxt = wrap ? '0 : refresh_cnt + CNT_W'(1);

      // a REF issued on the same cycle as an expiry services that expiry
      if (clear_ok && !wrap) begin
`ifdef REF_PULL_IN_EN
        if (pend != 4'd0) pend_nxt = pend - 4'd1;
        else              credit_nxt = credit + 4'd1;
`else
        pend_nxt = pend - 4'd1;
`endif
      end else if (wrap && !clear_ok) begin
`ifdef REF_PULL_IN_EN
        if (credit != 4'd0)         credit_nxt = credit - 4'd1;
        else if (pend < PEND_MAX)   pend_nxt = pend + 4'd1;
`else
        if (pend < PEND_MAX) pend_nxt = pend + 4'd1;
`endif
      end

      unique case (state)
        IDLE:  state_nxt = COUNT;
        COUNT: begin
          if (due) begin
            state_nxt = REQ;
`ifdef REF_PULL_IN_EN
          end else if ((pend == 4'd0) && both_idle) begin
            idle_cnt_nxt = (idle_cnt == 4'd15) ? idle_cnt : idle_cnt + 4'd1;
            if ((idle_cnt == 4'd15) && (credit < PEND_MAX))
              state_nxt = REQ;
`endif
          end
        end
        REQ: begin
          if (clear_ok) begin
            state_nxt   = RFC;
            rfc_cnt_nxt = '0;
          end else if (!urgent_now && !both_idle) begin
            state_nxt = COUNT;
          end
        end
        RFC: begin
          if (rfc_cnt == TRFC_LAST) begin
            done_nxt  = 1'b1;
            state_nxt = due ? REQ : COUNT;
          end else begin
            rfc_cnt_nxt = rfc_cnt + CNT_W'(1);
          end
        end
        default: state_nxt = IDLE;
      endcase
    end

    almost_nxt = (state_nxt != IDLE) && ((pend_nxt != 4'd0) || (refresh_cnt_nxt >= ALMOST_AT));
`ifdef REF_PULL_IN_EN
    if (credit_nxt != 4'd0) almost_nxt = 1'b0;
`endif
  end

  assign rif.refresh_almost = almost_q;
  assign rif.refresh_rdy    = rdy_q;
  assign rif.refresh_urgent = urgent_q;
  assign rif.busy           = busy_q;
  assign rif.refresh_done   = done_q;
  assign rif.pend_cnt       = pend;

endmodule

// File: tb/tb_ddr_refresh_ctrl.sv
// Scoreboard bench for ddr_refresh_ctrl with TREFI=100, TRFC=10, ALMOST_WINDOW=8, MAX_POSTPONE=4.
module tb_ddr_refresh_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  int         cyc_q[$];
  logic [8:0] out_q[$];
  string      name_q[$];
  logic [8:0] prev = '0;
  logic [8:0] cur;

  ddr_refresh_if rif();

  ddr_refresh_ctrl #(
    .TREFI(100), .TRFC(10), .ALMOST_WINDOW(8), .MAX_POSTPONE(4), .CNT_W(16)
  ) dut (
    .CK_t(clk),
    .RESET_n(rst_n),
    .rif(rif)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  assign cur = {rif.pend_cnt, rif.refresh_almost, rif.refresh_rdy,
                rif.refresh_urgent, rif.busy, rif.refresh_done};

  // expected output vector {pend, almost, rdy, urgent, busy, done} at a given cycle
  task automatic expect_at(input int c, input logic [3:0] p, input logic a, input logic r,
                           input logic u, input logic b, input logic d, input string nm);
    cyc_q.push_back(c);
    out_q.push_back({p, a, r, u, b, d});
    name_q.push_back(nm);
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pop_check(input logic [8:0] v);
    int         c;
    logic [8:0] o;
    string      nm;
    c  = cyc_q.pop_front();
    o  = out_q.pop_front();
    nm = name_q.pop_front();
    checks++;
    if (c != cyc || o != v) begin
      errors++;
      $display("FAIL %s: cycle %0d outs %b, required cycle %0d outs %b", nm, cyc, v, c, o);
    end
  endtask

  // monitor: compare on scheduled cycles and on any output change
  always @(negedge clk) begin
    if (cyc_q.size() > 0 && cyc_q[0] <= cyc) begin
      pop_check(cur);
    end else if (cur != prev) begin
      if (cyc_q.size() > 0) begin
        pop_check(cur);
      end else begin
        checks++;
        errors++;
        $display("FAIL unexpected_change: cycle %0d outs %b, required unchanged %b", cyc, cur, prev);
      end
    end
    prev = cur;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int c1;
    rst_n = 1'b0;
    rif.ini_done = 1'b0;
    rif.act_idle = 1'b1;
    rif.rw_idle = 1'b1;
    rif.clear_refresh = 1'b0;
    expect_at(1, 4'd0, 0, 0, 0, 0, 0, "reset_state");
    wait_cyc(3);
    rst_n = 1'b1;
    wait_cyc(5);
    c = cyc;
    rif.ini_done = 1'b1;
`ifndef REF_PULL_IN_EN
    expect_at(c+93,  4'd0, 1, 0, 0, 0, 0, "almost_at_92");
    expect_at(c+101, 4'd1, 1, 0, 0, 0, 0, "first_wrap");
    expect_at(c+102, 4'd1, 1, 1, 0, 0, 0, "rdy_after_wrap");
    expect_at(c+103, 4'd0, 0, 0, 0, 1, 0, "rfc_start");
    expect_at(c+113, 4'd0, 0, 0, 0, 0, 1, "done_pulse");
    expect_at(c+114, 4'd0, 0, 0, 0, 0, 0, "done_clear");
    expect_at(c+193, 4'd0, 1, 0, 0, 0, 0, "almost_2");
    expect_at(c+201, 4'd1, 1, 0, 0, 0, 0, "postpone_1");
    expect_at(c+301, 4'd2, 1, 0, 0, 0, 0, "postpone_2");
    expect_at(c+401, 4'd3, 1, 0, 0, 0, 0, "postpone_3");
    expect_at(c+501, 4'd4, 1, 0, 1, 0, 0, "urgent_set");
    expect_at(c+502, 4'd4, 1, 1, 1, 0, 0, "urgent_rdy");
    expect_at(c+601, 4'd4, 1, 1, 1, 0, 0, "pend_saturated");
    expect_at(c+603, 4'd3, 1, 0, 0, 1, 0, "rfc_from_urgent");
    expect_at(c+613, 4'd3, 1, 1, 0, 0, 1, "done_back_to_req");
    expect_at(c+614, 4'd3, 1, 1, 0, 0, 0, "done_clear_3");
    expect_at(c+615, 4'd2, 1, 0, 0, 1, 0, "rfc_pend_2");
    expect_at(c+625, 4'd2, 1, 1, 0, 0, 1, "done_pend_2");
    expect_at(c+626, 4'd2, 1, 1, 0, 0, 0, "req_pend_2");
    expect_at(c+701, 4'd2, 1, 0, 0, 1, 0, "clear_with_wrap");
    expect_at(c+711, 4'd2, 1, 1, 0, 0, 1, "rdy_reasserts");
    expect_at(c+712, 4'd2, 1, 1, 0, 0, 0, "req_after_wrap_clear");
    expect_at(c+713, 4'd1, 1, 0, 0, 1, 0, "drain_rfc_1");
    expect_at(c+723, 4'd1, 1, 1, 0, 0, 1, "drain_done_1");
    expect_at(c+724, 4'd1, 1, 1, 0, 0, 0, "drain_req_1");
    expect_at(c+725, 4'd0, 0, 0, 0, 1, 0, "drain_rfc_0");
    expect_at(c+735, 4'd0, 0, 0, 0, 0, 1, "drain_done_0");
    expect_at(c+736, 4'd0, 0, 0, 0, 0, 0, "drain_idle");
    expect_at(c+742, 4'd0, 0, 0, 0, 0, 0, "clear_in_count_ignored");
    expect_at(c+793, 4'd0, 1, 0, 0, 0, 0, "almost_3");
    expect_at(c+801, 4'd1, 1, 0, 0, 0, 0, "wrap_8");
    expect_at(c+802, 4'd1, 1, 1, 0, 0, 0, "rdy_8");
    expect_at(c+803, 4'd0, 0, 0, 0, 1, 0, "rfc_8");
    expect_at(c+807, 4'd0, 0, 0, 0, 0, 0, "ini_drop_mid_rfc");
    expect_at(c+814, 4'd0, 0, 0, 0, 0, 0, "no_done_after_drop");
    wait_cyc(c+102); rif.clear_refresh = 1'b1;
    wait_cyc(c+103); rif.clear_refresh = 1'b0;
    wait_cyc(c+114); rif.act_idle = 1'b0;
    wait_cyc(c+601); rif.act_idle = 1'b1;
    wait_cyc(c+602); rif.clear_refresh = 1'b1;
    wait_cyc(c+603); rif.clear_refresh = 1'b0;
    wait_cyc(c+614); rif.clear_refresh = 1'b1;
    wait_cyc(c+615); rif.clear_refresh = 1'b0;
    wait_cyc(c+700); rif.clear_refresh = 1'b1;
    wait_cyc(c+701); rif.clear_refresh = 1'b0;
    wait_cyc(c+712); rif.clear_refresh = 1'b1;
    wait_cyc(c+713); rif.clear_refresh = 1'b0;
    wait_cyc(c+724); rif.clear_refresh = 1'b1;
    wait_cyc(c+725); rif.clear_refresh = 1'b0;
    wait_cyc(c+740); rif.clear_refresh = 1'b1;
    wait_cyc(c+741); rif.clear_refresh = 1'b0;
    wait_cyc(c+802); rif.clear_refresh = 1'b1;
    wait_cyc(c+803); rif.clear_refresh = 1'b0;
    wait_cyc(c+806); rif.ini_done = 1'b0;
    c1 = c + 820;
    expect_at(c1+93,  4'd0, 1, 0, 0, 0, 0, "reinit_almost");
    expect_at(c1+101, 4'd1, 1, 0, 0, 0, 0, "reinit_wrap");
    expect_at(c1+102, 4'd1, 1, 1, 0, 0, 0, "reinit_rdy");
    expect_at(c1+105, 4'd0, 0, 0, 0, 0, 0, "async_reset_mid_req");
    expect_at(c1+110, 4'd0, 0, 0, 0, 0, 0, "after_reset_release");
    wait_cyc(c1); rif.ini_done = 1'b1;
    wait_cyc(c1+105);
    #2 rst_n = 1'b0;
    wait_cyc(c1+108); rst_n = 1'b1;
    wait_cyc(c1+115);
`else
    expect_at(c+17,  4'd0, 0, 1, 0, 0, 0, "pullin_rdy_1");
    expect_at(c+18,  4'd0, 0, 0, 0, 1, 0, "pullin_rfc_1");
    expect_at(c+28,  4'd0, 0, 0, 0, 0, 1, "pullin_done_1");
    expect_at(c+29,  4'd0, 0, 0, 0, 0, 0, "pullin_idle_1");
    expect_at(c+44,  4'd0, 0, 1, 0, 0, 0, "pullin_rdy_2");
    expect_at(c+45,  4'd0, 0, 0, 0, 1, 0, "pullin_rfc_2");
    expect_at(c+55,  4'd0, 0, 0, 0, 0, 1, "pullin_done_2");
    expect_at(c+56,  4'd0, 0, 0, 0, 0, 0, "pullin_idle_2");
    expect_at(c+102, 4'd0, 0, 0, 0, 0, 0, "credit_wrap_1");
    expect_at(c+194, 4'd0, 0, 0, 0, 0, 0, "almost_suppressed");
    expect_at(c+202, 4'd0, 0, 0, 0, 0, 0, "credit_wrap_2");
    expect_at(c+293, 4'd0, 1, 0, 0, 0, 0, "almost_after_credit");
    expect_at(c+301, 4'd1, 1, 0, 0, 0, 0, "third_wrap_pend");
    expect_at(c+303, 4'd1, 1, 0, 0, 0, 0, "no_req_not_idle");
    wait_cyc(c+17); rif.clear_refresh = 1'b1;
    wait_cyc(c+18); rif.clear_refresh = 1'b0;
    wait_cyc(c+44); rif.clear_refresh = 1'b1;
    wait_cyc(c+45); rif.clear_refresh = 1'b0;
    wait_cyc(c+46); rif.rw_idle = 1'b0;
    wait_cyc(c+305);
`endif
    if (cyc_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL missing_events: %0d expected entries left, required 0 (next %s at cycle %0d)",
               cyc_q.size(), name_q[0], cyc_q[0]);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
